// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types and encodings for the memory port arbiter.
//   state_e : arbiter FSM states
//   owner_e : which requester owns the outstanding transaction
//   M_*     : memory function codes (read / write)
//   MT_*    : access size / sign codes
// Optional feature macro used by the arbiter: MEM_ARB_STARVE_GUARD_EN
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IMEM = 1'b0,
    OWN_DMEM = 1'b1
  } owner_e;

  localparam logic M_XRD = 1'b0;
  localparam logic M_XWR = 1'b1;

  localparam logic [2:0] MT_B  = 3'd1;
  localparam logic [2:0] MT_H  = 3'd2;
  localparam logic [2:0] MT_W  = 3'd3;
  localparam logic [2:0] MT_BU = 3'd5;
  localparam logic [2:0] MT_HU = 3'd6;
  localparam logic [2:0] MT_WU = 3'd7;

  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the imem, dmem and memory-side handshakes.
//   modport slave  : the arbiter's view (takes core requests and memory
//                    responses, drives core responses and the memory request)
//   modport master : the surrounding system's view (core ports + memory model)
// Parameters: ADDR_W, DATA_W.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // core instruction port
  logic              io_imem_req_valid;
  logic [ADDR_W-1:0] io_imem_req_bits_addr;
  logic              io_imem_resp_valid;
  logic [DATA_W-1:0] io_imem_resp_bits_data;
  // core data port
  logic              io_dmem_req_valid;
  logic [ADDR_W-1:0] io_dmem_req_bits_addr;
  logic [DATA_W-1:0] io_dmem_req_bits_data;
  logic              io_dmem_req_bits_fcn;
  logic [2:0]        io_dmem_req_bits_typ;
  logic              io_dmem_resp_valid;
  logic [DATA_W-1:0] io_dmem_resp_bits_data;
  // memory side
  logic              io_mem_req_valid;
  logic              io_mem_req_ready;
  logic [ADDR_W-1:0] io_mem_req_bits_addr;
  logic [DATA_W-1:0] io_mem_req_bits_data;
  logic              io_mem_req_bits_fcn;
  logic [2:0]        io_mem_req_bits_typ;
  logic              io_mem_resp_valid;
  logic [DATA_W-1:0] io_mem_resp_bits_data;

  modport slave (
    input  io_imem_req_valid, io_imem_req_bits_addr,
    output io_imem_resp_valid, io_imem_resp_bits_data,
    input  io_dmem_req_valid, io_dmem_req_bits_addr, io_dmem_req_bits_data,
    input  io_dmem_req_bits_fcn, io_dmem_req_bits_typ,
    output io_dmem_resp_valid, io_dmem_resp_bits_data,
    output io_mem_req_valid, io_mem_req_bits_addr, io_mem_req_bits_data,
    output io_mem_req_bits_fcn, io_mem_req_bits_typ,
    input  io_mem_req_ready, io_mem_resp_valid, io_mem_resp_bits_data
  );

  modport master (
    output io_imem_req_valid, io_imem_req_bits_addr,
    input  io_imem_resp_valid, io_imem_resp_bits_data,
    output io_dmem_req_valid, io_dmem_req_bits_addr, io_dmem_req_bits_data,
    output io_dmem_req_bits_fcn, io_dmem_req_bits_typ,
    input  io_dmem_resp_valid, io_dmem_resp_bits_data,
    input  io_mem_req_valid, io_mem_req_bits_addr, io_mem_req_bits_data,
    input  io_mem_req_bits_fcn, io_mem_req_bits_typ,
    output io_mem_req_ready, io_mem_resp_valid, io_mem_resp_bits_data
  );
endinterface

// File: rtl/mem_port_arbiter_starve_guard.sv
// mem_arb_starve_guard: counts dmem grants won while imem was also waiting
// and raises force_imem once the count reaches STARVE_LIMIT.
//   clock, reset  : clock, async active-high reset
//   grant_imem    : arbiter grants imem this cycle (clears the count)
//   grant_dmem    : arbiter grants dmem this cycle
//   imem_pending  : imem request is valid
//   force_imem    : imem must win the next arbitration
// Only instantiated when MEM_ARB_STARVE_GUARD_EN is defined.
module mem_arb_starve_guard
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic grant_imem,
  input  logic grant_dmem,
  input  logic imem_pending,
  output logic force_imem
);

  logic [STARVE_CNT_W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (grant_imem) begin
      count <= '0;
    end else if (grant_dmem && imem_pending && (count != '1)) begin
      // saturate so an out-of-range limit can never wrap back to zero
      count <= count + 1'b1;
    end
  end

  assign force_imem = (count == STARVE_CNT_W'(STARVE_LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the core's imem
// and dmem ports. One transaction outstanding, dmem has fixed priority.
//   clock : sole clock
//   reset : asynchronous, active-high
//   bus   : mem_port_arbiter_if.slave (imem, dmem and memory handshakes)
// Optional: MEM_ARB_STARVE_GUARD_EN adds a starvation guard that forces an
// imem grant after STARVE_LIMIT dmem grants made while imem was pending.
//
// state | meaning
// IDLE  | no transaction; arbitrate and capture the winner's request
// ISSUE | io_mem_req_valid high with captured bits until io_mem_req_ready
// WAIT  | request accepted; route io_mem_resp_valid to the owner
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic              clock,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);

  state_e            state, state_nxt;
  owner_e            owner;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              fcn_q;
  logic [2:0]        typ_q;

  logic grant_imem, grant_dmem, force_imem, resp_fire;

`ifdef MEM_ARB_STARVE_GUARD_EN
  mem_arb_starve_guard #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_guard (
    .clock       (clock),
    .reset       (reset),
    .grant_imem  (grant_imem),
    .grant_dmem  (grant_dmem),
    .imem_pending(bus.io_imem_req_valid),
    .force_imem  (force_imem)
  );
`else
  logic unused_starve_limit;
  assign unused_starve_limit = ^STARVE_LIMIT;
  assign force_imem          = 1'b0;
`endif

  always_comb begin
    grant_imem = 1'b0;
    grant_dmem = 1'b0;
    if (state == IDLE) begin
      if (bus.io_imem_req_valid && (!bus.io_dmem_req_valid || force_imem)) begin
        grant_imem = 1'b1;
      end else if (bus.io_dmem_req_valid) begin
        grant_dmem = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_imem || grant_dmem) state_nxt = ISSUE;
      ISSUE:   if (bus.io_mem_req_ready)     state_nxt = WAIT;
      WAIT:    if (bus.io_mem_resp_valid)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      owner  <= OWN_DMEM;
      addr_q <= '0;
      data_q <= '0;
      fcn_q  <= M_XRD;
      typ_q  <= '0;
    end else begin
      state <= state_nxt;
      if (grant_imem) begin
        owner  <= OWN_IMEM;
        addr_q <= bus.io_imem_req_bits_addr;
        data_q <= '0;
        fcn_q  <= M_XRD;
        typ_q  <= MT_WU;
      end else if (grant_dmem) begin
        owner  <= OWN_DMEM;
        addr_q <= bus.io_dmem_req_bits_addr;
        data_q <= bus.io_dmem_req_bits_data;
        fcn_q  <= bus.io_dmem_req_bits_fcn;
        typ_q  <= bus.io_dmem_req_bits_typ;
      end
    end
  end

  // Responses outside WAIT are spurious and dropped.
  assign resp_fire = (state == WAIT) && bus.io_mem_resp_valid;

  always_comb begin
    bus.io_imem_resp_valid     = 1'b0;
    bus.io_imem_resp_bits_data = '0;
    bus.io_dmem_resp_valid     = 1'b0;
    bus.io_dmem_resp_bits_data = '0;
    if (resp_fire) begin
      if (owner == OWN_IMEM) begin
        bus.io_imem_resp_valid     = 1'b1;
        bus.io_imem_resp_bits_data = bus.io_mem_resp_bits_data;
      end else begin
        bus.io_dmem_resp_valid     = 1'b1;
        bus.io_dmem_resp_bits_data = bus.io_mem_resp_bits_data;
      end
    end
  end

  assign bus.io_mem_req_valid     = (state == ISSUE);
  assign bus.io_mem_req_bits_addr = addr_q;
  assign bus.io_mem_req_bits_data = data_q;
  assign bus.io_mem_req_bits_fcn  = fcn_q;
  assign bus.io_mem_req_bits_typ  = typ_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter. Inputs change on
// the falling edge and outputs are sampled 1 ns later. Expectations for the
// starvation test depend on MEM_ARB_STARVE_GUARD_EN.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_no_resp(input string tag);
    chk({tag, "_iv"}, 32'(bus.io_imem_resp_valid), 32'd0);
    chk({tag, "_dv"}, 32'(bus.io_dmem_resp_valid), 32'd0);
  endtask

  initial begin
    logic exp_imem;
    reset                     = 1'b1;
    bus.io_imem_req_valid     = 1'b0;
    bus.io_imem_req_bits_addr = '0;
    bus.io_dmem_req_valid     = 1'b0;
    bus.io_dmem_req_bits_addr = '0;
    bus.io_dmem_req_bits_data = '0;
    bus.io_dmem_req_bits_fcn  = 1'b0;
    bus.io_dmem_req_bits_typ  = '0;
    bus.io_mem_req_ready      = 1'b0;
    bus.io_mem_resp_valid     = 1'b0;
    bus.io_mem_resp_bits_data = '0;

    // reset state
    repeat (2) @(negedge clock);
    #1;
    chk("rst_mvalid", 32'(bus.io_mem_req_valid), 32'd0);
    chk("rst_addr",   bus.io_mem_req_bits_addr,  32'd0);
    chk("rst_data",   bus.io_mem_req_bits_data,  32'd0);
    chk("rst_fcn",    32'(bus.io_mem_req_bits_fcn), 32'd0);
    chk("rst_typ",    32'(bus.io_mem_req_bits_typ), 32'd0);
    chk_no_resp("rst");
    chk("rst_state",  32'(dut.state), 32'(IDLE));
    @(negedge clock);
    reset = 1'b0;

    // 1: imem-only read
    @(negedge clock);
    bus.io_imem_req_valid     = 1'b1;
    bus.io_imem_req_bits_addr = 32'h100;
    bus.io_mem_req_ready      = 1'b1;
    #1 chk("t1_idle_mvalid", 32'(bus.io_mem_req_valid), 32'd0);
    @(negedge clock); #1;
    chk("t1_mvalid", 32'(bus.io_mem_req_valid), 32'd1);
    chk("t1_addr",   bus.io_mem_req_bits_addr, 32'h100);
    chk("t1_typ",    32'(bus.io_mem_req_bits_typ), 32'd7);
    chk("t1_fcn",    32'(bus.io_mem_req_bits_fcn), 32'd0);
    chk("t1_data",   bus.io_mem_req_bits_data, 32'd0);
    @(negedge clock);
    bus.io_mem_resp_valid     = 1'b1;
    bus.io_mem_resp_bits_data = 32'hDEADBEEF;
    #1;
    chk("t1_wait_mvalid", 32'(bus.io_mem_req_valid), 32'd0);
    chk("t1_iv",    32'(bus.io_imem_resp_valid), 32'd1);
    chk("t1_idata", bus.io_imem_resp_bits_data, 32'hDEADBEEF);
    chk("t1_dv",    32'(bus.io_dmem_resp_valid), 32'd0);
    chk("t1_ddata", bus.io_dmem_resp_bits_data, 32'd0);
    @(negedge clock);
    bus.io_imem_req_valid = 1'b0;
    bus.io_mem_resp_valid = 1'b0;
    #1 chk("t1_pulse_once", 32'(bus.io_imem_resp_valid), 32'd0);

    // 2: simultaneous imem read and dmem store; dmem first
    @(negedge clock);
    bus.io_imem_req_valid     = 1'b1;
    bus.io_imem_req_bits_addr = 32'h200;
    bus.io_dmem_req_valid     = 1'b1;
    bus.io_dmem_req_bits_addr = 32'h400;
    bus.io_dmem_req_bits_data = 32'h55;
    bus.io_dmem_req_bits_fcn  = M_XWR;
    bus.io_dmem_req_bits_typ  = MT_W;
    @(negedge clock); #1;
    chk("t2_d_addr", bus.io_mem_req_bits_addr, 32'h400);
    chk("t2_d_fcn",  32'(bus.io_mem_req_bits_fcn), 32'd1);
    chk("t2_d_data", bus.io_mem_req_bits_data, 32'h55);
    chk("t2_d_typ",  32'(bus.io_mem_req_bits_typ), 32'd3);
    @(negedge clock);
    bus.io_mem_resp_valid     = 1'b1;
    bus.io_mem_resp_bits_data = 32'h0;
    #1;
    chk("t2_d_dv", 32'(bus.io_dmem_resp_valid), 32'd1);
    chk("t2_d_iv", 32'(bus.io_imem_resp_valid), 32'd0);
    @(negedge clock);
    bus.io_dmem_req_valid = 1'b0;
    bus.io_mem_resp_valid = 1'b0;
    #1;
    chk_no_resp("t2_gap");
    chk("t2_gap_mvalid", 32'(bus.io_mem_req_valid), 32'd0);
    @(negedge clock); #1;
    chk("t2_i_addr", bus.io_mem_req_bits_addr, 32'h200);
    chk("t2_i_fcn",  32'(bus.io_mem_req_bits_fcn), 32'd0);
    chk("t2_i_typ",  32'(bus.io_mem_req_bits_typ), 32'd7);
    chk("t2_i_data", bus.io_mem_req_bits_data, 32'd0);
    @(negedge clock);
    bus.io_mem_resp_valid     = 1'b1;
    bus.io_mem_resp_bits_data = 32'h12345678;
    #1;
    chk("t2_i_iv",    32'(bus.io_imem_resp_valid), 32'd1);
    chk("t2_i_idata", bus.io_imem_resp_bits_data, 32'h12345678);
    chk("t2_i_dv",    32'(bus.io_dmem_resp_valid), 32'd0);
    chk("t2_i_ddata", bus.io_dmem_resp_bits_data, 32'd0);
    @(negedge clock);
    bus.io_imem_req_valid = 1'b0;
    bus.io_mem_resp_valid = 1'b0;

    // 3: ready held low for 5 cycles in ISSUE; later request bits ignored
    bus.io_dmem_req_valid     = 1'b1;
    bus.io_dmem_req_bits_addr = 32'h80;
    bus.io_dmem_req_bits_data = 32'h0;
    bus.io_dmem_req_bits_fcn  = M_XRD;
    bus.io_dmem_req_bits_typ  = MT_BU;
    bus.io_mem_req_ready      = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clock);
      bus.io_dmem_req_bits_addr = 32'h999 + 32'(i);
      bus.io_dmem_req_bits_typ  = MT_H;
      bus.io_mem_resp_valid     = (i % 2 == 1);
      #1;
      chk("t3_mvalid", 32'(bus.io_mem_req_valid), 32'd1);
      chk("t3_addr",   bus.io_mem_req_bits_addr, 32'h80);
      chk("t3_typ",    32'(bus.io_mem_req_bits_typ), 32'd5);
      chk_no_resp("t3_issue");
    end
    bus.io_mem_req_ready  = 1'b1;
    bus.io_mem_resp_valid = 1'b0;
    @(negedge clock);
    bus.io_mem_resp_valid     = 1'b1;
    bus.io_mem_resp_bits_data = 32'hA5;
    #1;
    chk("t3_mvalid_off", 32'(bus.io_mem_req_valid), 32'd0);
    chk("t3_dv",    32'(bus.io_dmem_resp_valid), 32'd1);
    chk("t3_ddata", bus.io_dmem_resp_bits_data, 32'hA5);
    @(negedge clock);
    bus.io_dmem_req_valid = 1'b0;
    bus.io_mem_resp_valid = 1'b0;

    // 4: dmem back-to-back with imem pending
    bus.io_imem_req_valid     = 1'b1;
    bus.io_imem_req_bits_addr = 32'h300;
    bus.io_dmem_req_valid     = 1'b1;
    bus.io_dmem_req_bits_fcn  = M_XRD;
    bus.io_dmem_req_bits_typ  = MT_W;
    for (int k = 0; k < 5; k++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_imem = (k == 4);
`else
      exp_imem = 1'b0;
`endif
      if (k > 0) @(negedge clock);
      bus.io_mem_resp_valid     = 1'b0;
      bus.io_dmem_req_bits_addr = 32'h1000 + 32'(4 * k);
      #1;
      chk("t4_idle_mvalid", 32'(bus.io_mem_req_valid), 32'd0);
`ifdef MEM_ARB_STARVE_GUARD_EN
      chk("t4_cnt", 32'(dut.u_guard.count), 32'(k));
`endif
      @(negedge clock); #1;
      chk("t4_addr", bus.io_mem_req_bits_addr,
          exp_imem ? 32'h300 : (32'h1000 + 32'(4 * k)));
      @(negedge clock);
      bus.io_mem_resp_valid     = 1'b1;
      bus.io_mem_resp_bits_data = 32'(k);
      #1;
      chk("t4_iv", 32'(bus.io_imem_resp_valid), 32'(exp_imem));
      chk("t4_dv", 32'(bus.io_dmem_resp_valid), 32'(!exp_imem));
    end
    @(negedge clock);
    bus.io_mem_resp_valid = 1'b0;
    bus.io_dmem_req_valid = 1'b0;
    #1;
`ifdef MEM_ARB_STARVE_GUARD_EN
    chk("t4_cnt_after", 32'(dut.u_guard.count), 32'd0);
`endif
    @(negedge clock); #1;
    chk("t4_last_addr", bus.io_mem_req_bits_addr, 32'h300);
    @(negedge clock);
    bus.io_mem_resp_valid     = 1'b1;
    bus.io_mem_resp_bits_data = 32'h3;
    #1 chk("t4_last_iv", 32'(bus.io_imem_resp_valid), 32'd1);
    @(negedge clock);
    bus.io_imem_req_valid = 1'b0;
    bus.io_mem_resp_valid = 1'b0;

    // 5a: spurious response in IDLE
    bus.io_mem_resp_valid     = 1'b1;
    bus.io_mem_resp_bits_data = 32'hBAD;
    #1 chk_no_resp("t5_spur0");
    @(negedge clock); #1;
    chk_no_resp("t5_spur1");
    chk("t5_spur_mvalid", 32'(bus.io_mem_req_valid), 32'd0);
    chk("t5_spur_state",  32'(dut.state), 32'(IDLE));

    // 5b: reset during WAIT abandons the transaction
    @(negedge clock);
    bus.io_mem_resp_valid     = 1'b0;
    bus.io_dmem_req_valid     = 1'b1;
    bus.io_dmem_req_bits_addr = 32'h44;
    bus.io_dmem_req_bits_typ  = MT_W;
    bus.io_mem_req_ready      = 1'b1;
    @(negedge clock); #1;
    chk("t5_issue", 32'(bus.io_mem_req_valid), 32'd1);
    @(negedge clock); #1;
    chk("t5_wait_state", 32'(dut.state), 32'(WAIT));
    reset                     = 1'b1;
    bus.io_mem_resp_valid     = 1'b1;
    bus.io_mem_resp_bits_data = 32'h77;
    #1;
    chk("t5_rst_state",  32'(dut.state), 32'(IDLE));
    chk("t5_rst_mvalid", 32'(bus.io_mem_req_valid), 32'd0);
    chk("t5_rst_addr",   bus.io_mem_req_bits_addr, 32'd0);
    chk("t5_rst_typ",    32'(bus.io_mem_req_bits_typ), 32'd0);
    chk("t5_rst_ddata",  bus.io_dmem_resp_bits_data, 32'd0);
    chk_no_resp("t5_rst");
    @(negedge clock);
    reset                 = 1'b0;
    bus.io_dmem_req_valid = 1'b0;
    #1 chk_no_resp("t5_late0");
    @(negedge clock); #1;
    chk_no_resp("t5_late1");
    chk("t5_late_state", 32'(dut.state), 32'(IDLE));
    bus.io_mem_resp_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
